// File: rtl/uart_cfg_if.sv
// uart_cfg_if: bundles the transmit handshake, receive results and the serial
// pins of uart_cfg. The slave modport is the UART side; the master modport is
// the user side (FIFO/command logic plus whatever drives the rx pin).
interface uart_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_start, tx_data, rx,
    input  tx, tx_busy, tx_done, rx_data, rx_done, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_start, tx_data, rx,
    output tx, tx_busy, tx_done, rx_data, rx_done, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_cfg.sv
// uart_cfg: parametrised full-duplex UART with a shared free-running baud tick.
// Optional even/odd parity is enabled by defining UART_PARITY_EN; without it
// the parity bit is neither sent nor expected and rx_parity_err reads 0.
module uart_cfg #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input logic      clk,
  input logic      rst,
  uart_cfg_if.slave bus
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE) - 1;
  localparam int TW  = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [TW-1:0] DIV_LAST  = TW'(DIV);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  // Shared state encoding for both directions.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

`ifdef UART_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  logic tx_par_reg;
  logic rx_par_bad_reg;
  logic rx_parity_err_reg;
  assign bus.rx_parity_err = rx_parity_err_reg;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
  assign bus.rx_parity_err = 1'b0;
`endif

  logic [TW-1:0] div_cnt;
  logic          tick;

  logic [2:0]           tx_state;
  logic [OW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_reg, tx_busy_reg, tx_done_reg;

  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic [2:0]           rx_state;
  logic                 rx_armed;
  logic [OW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift, rx_data_reg;
  logic                 rx_done_reg, rx_frame_err_reg;

  assign rx_s             = rx_sync[1];
  assign bus.tx           = tx_reg;
  assign bus.tx_busy      = tx_busy_reg;
  assign bus.tx_done      = tx_done_reg;
  assign bus.rx_data      = rx_data_reg;
  assign bus.rx_done      = rx_done_reg;
  assign bus.rx_frame_err = rx_frame_err_reg;

  // Free-running oversample tick: one-cycle pulse every DIV+1 clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Transmitter: accepts in IDLE, then walks start/data/[parity]/stop bits of OVERSAMPLE ticks each.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= S_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      tx_reg      <= 1'b1;
      tx_busy_reg <= 1'b0;
      tx_done_reg <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_reg  <= 1'b0;
`endif
    end else begin
      tx_done_reg <= 1'b0;
      if (tx_state == S_IDLE) begin
        tx_reg <= 1'b1;
        if (bus.tx_start) begin
          tx_shift    <= bus.tx_data;
`ifdef UART_PARITY_EN
          tx_par_reg  <= (^bus.tx_data) ^ ODD_BIT;
`endif
          tx_cnt      <= '0;
          tx_bit      <= '0;
          tx_state    <= S_START;
          tx_reg      <= 1'b0;
          tx_busy_reg <= 1'b1;
        end
      end else if (tick) begin
        if (tx_cnt != OS_LAST) begin
          tx_cnt <= tx_cnt + 1'b1;
        end else begin
          tx_cnt <= '0;
          case (tx_state)
            S_START: begin
              tx_state <= S_DATA;
              tx_reg   <= tx_shift[0];
            end
            S_DATA: begin
              if (tx_bit == DATA_LAST) begin
                tx_bit <= '0;
`ifdef UART_PARITY_EN
                tx_state <= S_PARITY;
                tx_reg   <= tx_par_reg;
`else
                tx_state <= S_STOP;
                tx_reg   <= 1'b1;
`endif
              end else begin
                tx_bit   <= tx_bit + 1'b1;
                tx_shift <= tx_shift >> 1;
                tx_reg   <= tx_shift[1];
              end
            end
            S_PARITY: begin
              tx_state <= S_STOP;
              tx_reg   <= 1'b1;
            end
            S_STOP: begin
              if (tx_bit == STOP_LAST) begin
                tx_state    <= S_IDLE;
                tx_bit      <= '0;
                tx_busy_reg <= 1'b0;
                tx_done_reg <= 1'b1;
              end else begin
                tx_bit <= tx_bit + 1'b1;
              end
            end
            default: tx_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Receiver: synchronize rx, detect start when armed, sample each bit mid-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync          <= 2'b11;
      rx_state         <= S_IDLE;
      rx_armed         <= 1'b0;
      rx_cnt           <= '0;
      rx_bit           <= '0;
      rx_shift         <= '0;
      rx_data_reg      <= '0;
      rx_done_reg      <= 1'b0;
      rx_frame_err_reg <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_reg    <= 1'b0;
      rx_parity_err_reg <= 1'b0;
`endif
    end else begin
      rx_sync     <= {rx_sync[0], bus.rx};
      rx_done_reg <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          // A line held low (break, or low after a bad stop bit) never re-arms.
          if (rx_armed && !rx_s) begin
            rx_state <= S_START;
            rx_armed <= 1'b0;
          end else begin
            rx_armed <= rx_s;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_cnt != OS_HALF) begin
              rx_cnt <= rx_cnt + 1'b1;
            end else begin
              rx_cnt   <= '0;
              rx_state <= rx_s ? S_IDLE : S_DATA;
            end
          end
        end
        default: begin
          if (tick) begin
            if (rx_cnt != OS_LAST) begin
              rx_cnt <= rx_cnt + 1'b1;
            end else begin
              rx_cnt <= '0;
              if (rx_state == S_DATA) begin
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                if (rx_bit == DATA_LAST) begin
                  rx_bit <= '0;
`ifdef UART_PARITY_EN
                  rx_state <= S_PARITY;
`else
                  rx_state <= S_STOP;
`endif
                end else begin
                  rx_bit <= rx_bit + 1'b1;
                end
              end else if (rx_state == S_PARITY) begin
`ifdef UART_PARITY_EN
                rx_par_bad_reg <= rx_s ^ (^rx_shift) ^ ODD_BIT;
`endif
                rx_state <= S_STOP;
              end else begin
                // Only the first stop bit is checked; data is delivered even on error.
                rx_data_reg      <= rx_shift;
                rx_frame_err_reg <= ~rx_s;
`ifdef UART_PARITY_EN
                rx_parity_err_reg <= rx_par_bad_reg;
`endif
                rx_done_reg      <= 1'b1;
                rx_state         <= S_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: directed/randomized bench for uart_cfg at 160 clk per bit.
// dut1 is 8N1 with tx looped to rx (or rx driven by the bench); dut2 uses two
// stop bits for the back-to-back transmit case.
module tb_uart_cfg;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int BITCLK = 160;
  localparam int NB1 = 1 + 8 + P + 1;
  localparam int NB2 = 1 + 8 + P + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_sel = 1'b0;
  logic rx_drv = 1'b1;
  int tests = 0;
  int fails = 0;
  int rx_cnt1 = 0, txd_cnt1 = 0, busy_cyc1 = 0;
  int rx_cnt2 = 0, txd_cnt2 = 0;

  always #5 clk = ~clk;

  uart_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_cfg_if #(.DATA_BITS(8)) if2 ();

  assign if1.rx = rx_sel ? rx_drv : if1.tx;
  assign if2.rx = if2.tx;

  uart_cfg #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
             .STOP_BITS(1), .PARITY_ODD(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_cfg #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
             .STOP_BITS(2), .PARITY_ODD(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Event monitor: counts pulses and busy cycles away from the active edge.
  always @(negedge clk) begin
    if (if1.rx_done === 1'b1) rx_cnt1 <= rx_cnt1 + 1;
    if (if1.tx_done === 1'b1) txd_cnt1 <= txd_cnt1 + 1;
    if (if1.tx_busy === 1'b1) busy_cyc1 <= busy_cyc1 + 1;
    if (if2.rx_done === 1'b1) rx_cnt2 <= rx_cnt2 + 1;
    if (if2.tx_done === 1'b1) txd_cnt2 <= txd_cnt2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop ones.
  function automatic logic [15:0] model_frame(input logic [7:0] d, input int stops);
    logic [15:0] f;
    int ones;
    int idx;
    f = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = d[i];
      if (d[i]) ones++;
    end
    idx = 9;
    if (P == 1) begin
      f[idx] = ((ones % 2) == 1);
      idx++;
    end
    for (int s = 0; s < stops; s++) f[idx + s] = 1'b1;
    return f;
  endfunction

  function automatic logic line_of(input int which);
    return (which == 0) ? if1.tx : if2.tx;
  endfunction

  // Wait (bounded) for the start bit, then sample each bit at its middle.
  task automatic capture_frame(input int which, input int nb, output logic [15:0] bits,
                               output logic ok);
    int n;
    bits = '0;
    ok = 1'b1;
    n = 0;
    while (line_of(which) !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      ok = 1'b0;
    end else begin
      repeat (BITCLK / 2) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
        bits[i] = line_of(which);
        if (i < nb - 1) repeat (BITCLK) @(negedge clk);
      end
    end
  endtask

  // Bench-driven frame on dut1's rx pin; the line is left at stop_val.
  task automatic drive_frame(input logic [7:0] d, input logic stop_val, input logic par_flip);
    logic [15:0] f;
    f = model_frame(d, 1);
    rx_sel = 1'b1;
    for (int i = 0; i < 9 + P; i++) begin
      rx_drv = f[i];
      if (P == 1 && i == 9) rx_drv = f[i] ^ par_flip;
      repeat (BITCLK) @(negedge clk);
    end
    rx_drv = stop_val;
    repeat (BITCLK) @(negedge clk);
  endtask

  // Loopback transfer on dut1 with full checking of line, handshake and rx result.
  task automatic frame_check(input logic [7:0] d);
    int r0, t0, b0, n, blen;
    logic [15:0] bits;
    logic ok;
    r0 = rx_cnt1;
    t0 = txd_cnt1;
    b0 = busy_cyc1;
    @(negedge clk);
    if1.tx_start = 1'b1;
    if1.tx_data = d;
    @(negedge clk);
    if1.tx_start = 1'b0;
    check("busy_after_accept", {31'd0, if1.tx_busy}, 32'd1);
    check("start_bit_after_accept", {31'd0, if1.tx}, 32'd0);
    capture_frame(0, NB1, bits, ok);
    check("tx_frame_seen", {31'd0, ok}, 32'd1);
    check("tx_line_bits", {16'd0, bits}, {16'd0, model_frame(d, 1)});
    n = 0;
    while ((if1.tx_busy === 1'b1 || rx_cnt1 == r0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("frame_complete_in_time", {31'd0, (n < 1000)}, 32'd1);
    repeat (5) @(negedge clk);
    blen = busy_cyc1 - b0;
    check("rx_done_count", rx_cnt1 - r0, 32'd1);
    check("tx_done_count", txd_cnt1 - t0, 32'd1);
    check("rx_data", {24'd0, if1.rx_data}, {24'd0, d});
    check("rx_frame_err", {31'd0, if1.rx_frame_err}, 32'd0);
    check("rx_parity_err", {31'd0, if1.rx_parity_err}, 32'd0);
    check("tx_busy_length", {31'd0, (blen >= NB1 * BITCLK - 9 && blen <= NB1 * BITCLK)}, 32'd1);
    $display("[TB] loopback data=%02h rx_data=%02h busy=%0d clk", d, if1.rx_data, blen);
  endtask

  initial begin
    int r0, t0, n;
    logic [15:0] bits;
    logic ok;
    logic [7:0] d;
    if1.tx_start = 1'b0;
    if1.tx_data = 8'h00;
    if2.tx_start = 1'b0;
    if2.tx_data = 8'h00;

    // Reset values
    repeat (5) @(negedge clk);
    check("reset_tx", {31'd0, if1.tx}, 32'd1);
    check("reset_tx_busy", {31'd0, if1.tx_busy}, 32'd0);
    check("reset_tx_done", {31'd0, if1.tx_done}, 32'd0);
    check("reset_rx_data", {24'd0, if1.rx_data}, 32'd0);
    check("reset_rx_done", {31'd0, if1.rx_done}, 32'd0);
    check("reset_frame_err", {31'd0, if1.rx_frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, if1.rx_parity_err}, 32'd0);
    $display("[TB] reset values checked");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Loopback: fixed patterns then random payloads
    frame_check(8'hA5);
    frame_check(8'h07);
    for (int k = 0; k < 4; k++) frame_check(8'($urandom_range(0, 255)));

    // Back-to-back on the two-stop-bit instance, request held high
    t0 = txd_cnt2;
    r0 = rx_cnt2;
    @(negedge clk);
    if2.tx_start = 1'b1;
    if2.tx_data = 8'h3C;
    @(negedge clk);
    if2.tx_data = 8'hC3;
    capture_frame(1, NB2, bits, ok);
    check("b2b_first_seen", {31'd0, ok}, 32'd1);
    check("b2b_first_bits", {16'd0, bits}, {16'd0, model_frame(8'h3C, 2)});
    n = 0;
    while (if2.tx_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", {31'd0, (n < 400)}, 32'd1);
    @(negedge clk);
    check("b2b_second_start_no_gap", {31'd0, if2.tx}, 32'd0);
    check("b2b_second_busy", {31'd0, if2.tx_busy}, 32'd1);
    if2.tx_start = 1'b0;
    capture_frame(1, NB2, bits, ok);
    check("b2b_second_bits", {16'd0, bits}, {16'd0, model_frame(8'hC3, 2)});
    n = 0;
    while ((if2.tx_busy === 1'b1 || rx_cnt2 - r0 < 2) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (400) @(negedge clk);
    check("b2b_tx_done_count", txd_cnt2 - t0, 32'd2);
    check("b2b_rx_done_count", rx_cnt2 - r0, 32'd2);
    check("b2b_rx_data", {24'd0, if2.rx_data}, 32'hC3);
    $display("[TB] back-to-back 3C/C3 frames=%0d rx_data=%02h", txd_cnt2 - t0, if2.rx_data);

    // Short low glitch: false start, no rx_done
    r0 = rx_cnt1;
    rx_sel = 1'b1;
    rx_drv = 1'b0;
    repeat (40) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_no_rx_done", rx_cnt1 - r0, 32'd0);
    $display("[TB] 40-clk glitch rx_done_count=%0d", rx_cnt1 - r0);

    // Stop bit forced low, line then held low (break)
    r0 = rx_cnt1;
    drive_frame(8'h55, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    check("ferr_rx_done_count", rx_cnt1 - r0, 32'd1);
    check("ferr_rx_data", {24'd0, if1.rx_data}, 32'h55);
    check("ferr_flag", {31'd0, if1.rx_frame_err}, 32'd1);
    check("ferr_parity_flag", {31'd0, if1.rx_parity_err}, 32'd0);
    repeat (2000) @(negedge clk);
    check("break_no_rearm", rx_cnt1 - r0, 32'd1);
    rx_drv = 1'b1;
    repeat (50) @(negedge clk);
    $display("[TB] frame error data=%02h ferr=%0b", if1.rx_data, if1.rx_frame_err);

    // Good bench-driven frame after the break clears
    d = 8'($urandom_range(0, 255));
    r0 = rx_cnt1;
    drive_frame(d, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    check("post_break_rx_done_count", rx_cnt1 - r0, 32'd1);
    check("post_break_rx_data", {24'd0, if1.rx_data}, {24'd0, d});
    check("post_break_frame_err", {31'd0, if1.rx_frame_err}, 32'd0);
    $display("[TB] driven frame data=%02h rx_data=%02h", d, if1.rx_data);

`ifdef UART_PARITY_EN
    // Wrong parity on the line
    r0 = rx_cnt1;
    drive_frame(8'h07, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    check("par_flip_rx_done_count", rx_cnt1 - r0, 32'd1);
    check("par_flip_parity_err", {31'd0, if1.rx_parity_err}, 32'd1);
    check("par_flip_frame_err", {31'd0, if1.rx_frame_err}, 32'd0);
    check("par_flip_rx_data", {24'd0, if1.rx_data}, 32'h07);
    $display("[TB] flipped parity perr=%0b", if1.rx_parity_err);
`endif

    // Reset in the middle of a transfer
    rx_sel = 1'b0;
    repeat (50) @(negedge clk);
    r0 = rx_cnt1;
    t0 = txd_cnt1;
    @(negedge clk);
    if1.tx_start = 1'b1;
    if1.tx_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    if1.tx_start = 1'b0;
    repeat (BITCLK / 2 + 4 * BITCLK) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_tx", {31'd0, if1.tx}, 32'd1);
    check("mid_reset_busy", {31'd0, if1.tx_busy}, 32'd0);
    rst = 1'b0;
    repeat (2500) @(negedge clk);
    check("mid_reset_no_tx_done", txd_cnt1 - t0, 32'd0);
    check("mid_reset_no_rx_done", rx_cnt1 - r0, 32'd0);
    $display("[TB] reset mid-frame tx=%0b busy=%0b", if1.tx, if1.tx_busy);
    frame_check(8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
